// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-ported RAM between the instruction-fetch and the
//   data-access ports of the datapath. One transaction runs at a time. Data
//   normally wins; after MAX_DWIN consecutive data grants taken while an
//   instruction request was waiting, the instruction port is forced to win.
//   Request fields are captured at grant, so the RAM sees stable values even
//   if the pipeline changes its request mid-access.
//
// Parameters
//   MAX_DWIN   data grants allowed while iREN is pending (legal range 1..15)
//
// Ports
//   CLK        clock, rising edge
//   nRST       synchronous active-low reset
//   iREN       instruction read request (level)
//   iaddr      instruction address
//   iwait      instruction stall, low only in the completing cycle
//   iload      fetched instruction word
//   dREN/dWEN  data read/write request (level), both high means write
//   daddr      data address
//   dstore     data write value
//   dwait      data stall, low only in the completing cycle
//   dload      loaded data word
//   ramREN     RAM read strobe
//   ramWEN     RAM write strobe
//   ramaddr    RAM address
//   ramstore   RAM write data (0 on reads)
//   ramload    RAM read data, valid with ram_ready
//   ram_ready  one-cycle RAM completion pulse
//   owner      00 none, 01 instruction, 10 data
module ram_arbiter #(
  parameter int unsigned MAX_DWIN = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ram_ready,
  output logic [1:0]  owner
);

  // Encoding chosen so the state register drives owner directly.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    I_ACC = 2'b01,
    D_ACC = 2'b10
  } state_t;

  localparam logic [3:0] DWIN_LIMIT = 4'(MAX_DWIN);

  state_t      state;
  logic [31:0] lat_addr;
  logic [31:0] lat_store;
  logic        lat_wr;
  logic [3:0]  dwin;

  logic dreq;
  logic in_acc;
  logic i_done;
  logic d_done;

  assign dreq = dREN | dWEN;

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // branch is sampled on the clock edge because reset here is synchronous.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= IDLE;
      lat_addr  <= 32'h0;
      lat_store <= 32'h0;
      lat_wr    <= 1'b0;
      dwin      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          // dwin only reaches the limit while iREN has been waiting, so the
          // increment below never wraps for legal MAX_DWIN values.
          if (dreq && !(iREN && dwin == DWIN_LIMIT)) begin
            state     <= D_ACC;
            lat_addr  <= daddr;
            lat_store <= dstore;
            lat_wr    <= dWEN;
            dwin      <= iREN ? dwin + 4'd1 : 4'd0;
          end else if (iREN) begin
            state    <= I_ACC;
            lat_addr <= iaddr;
            lat_wr   <= 1'b0;
            dwin     <= 4'd0;
          end
        end
        I_ACC, D_ACC: begin
          // Leaving through IDLE gives the mandatory gap cycle between grants.
          if (ram_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the RAM-side outputs decode only registered state, so they cannot
  // glitch with datapath inputs and hold steady for the whole access.
  assign in_acc   = (state != IDLE);
  assign ramREN   = in_acc & ~lat_wr;
  assign ramWEN   = in_acc & lat_wr;
  assign ramaddr  = in_acc ? lat_addr : 32'h0;
  assign ramstore = (in_acc && lat_wr) ? lat_store : 32'h0;
  assign owner    = state;

  // Completion is masked while reset is asserted so each wait simply mirrors
  // its request during reset; an access being abandoned never completes.
  assign i_done = nRST & (state == I_ACC) & ram_ready;
  assign d_done = nRST & (state == D_ACC) & ram_ready;

  assign iwait = iREN & ~i_done;
  assign dwait = dreq & ~d_done;
  assign iload = (state == I_ACC) ? ramload : 32'h0;
  assign dload = (state == D_ACC) ? ramload : 32'h0;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
//   Directed scenarios followed by a randomized two-agent phase. The RAM is a
//   behavioural responder with configurable latency. Expected transactions are
//   queued when a request is issued and popped by a monitor on completion; a
//   separate predictor derives the owner sequence from the arbitration rules.
module tb_ram_arbiter;

  localparam int MAX_DWIN = 4;
  localparam int N_TXN    = 60;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = 32'h0;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = 32'h0;
  logic [31:0] dstore = 32'h0;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload = 32'h0;
  logic        ram_ready;
  logic [1:0]  owner;

  logic model_ready = 1'b0;
  logic force_ready = 1'b0;
  assign ram_ready = model_ready | force_ready;

  always #5 CLK = ~CLK;

  ram_arbiter #(.MAX_DWIN(MAX_DWIN)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .owner(owner)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Contents of never-written RAM locations.
  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  // ---------------- RAM responder ----------------
  logic [31:0] mem [logic [31:0]];
  int lat_min = 0;
  int lat_max = 0;
  bit in_acc  = 1'b0;
  int acc_cnt = 0;
  int acc_lat = 0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return rom(a);
  endfunction

  always @(posedge CLK) begin
    #2;
    model_ready = 1'b0;
    ramload     = $urandom;
    if (ramREN || ramWEN) begin
      if (!in_acc) begin
        in_acc  = 1'b1;
        acc_cnt = 0;
        acc_lat = $urandom_range(lat_max, lat_min);
      end else begin
        acc_cnt++;
      end
      if (acc_cnt >= acc_lat) begin
        model_ready = 1'b1;
        in_acc      = 1'b0;
        if (ramWEN) mem[ramaddr] = ramstore;
        else        ramload      = mem_rd(ramaddr);
      end
    end else begin
      in_acc = 1'b0;
    end
  end

  // ---------------- owner predictor ----------------
  logic [1:0] m_owner = 2'b00;
  bit         m_valid = 1'b0;
  int         streak  = 0;

  always @(negedge CLK) begin
    if (m_valid) check("owner", 32'(owner), 32'(m_owner));
    if (!nRST) begin
      m_owner = 2'b00;
      streak  = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_owner == 2'b00) begin
        if ((dREN || dWEN) && !(iREN && streak == MAX_DWIN)) begin
          m_owner = 2'b10;
          streak  = iREN ? streak + 1 : 0;
        end else if (iREN) begin
          m_owner = 2'b01;
          streak  = 0;
        end
      end else if (ram_ready) begin
        m_owner = 2'b00;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] data;
    bit          wr;
  } txn_t;

  txn_t iq[$];
  txn_t dq[$];
  logic [31:0] shadow [logic [31:0]];
  bit sb_on = 1'b0;

  always @(negedge CLK) begin
    if (sb_on) begin
      if (owner == 2'b01 && iq.size() > 0) begin
        check("i_ramaddr", ramaddr, iq[0].addr);
        check("i_strobes", 32'({ramREN, ramWEN}), 32'h2);
        check("i_ramstore", ramstore, 32'h0);
      end
      if (owner == 2'b10 && dq.size() > 0) begin
        check("d_ramaddr", ramaddr, dq[0].addr);
        check("d_strobes", 32'({ramREN, ramWEN}), dq[0].wr ? 32'h1 : 32'h2);
        check("d_ramstore", ramstore, dq[0].wr ? dq[0].store : 32'h0);
      end
      if (iREN && !iwait) begin
        if (iq.size() == 0) check("i_unexpected_done", 32'h1, 32'h0);
        else begin
          check("iload", iload, iq[0].data);
          void'(iq.pop_front());
        end
      end
      if ((dREN || dWEN) && !dwait) begin
        if (dq.size() == 0) check("d_unexpected_done", 32'h1, 32'h0);
        else begin
          if (!dq[0].wr) check("dload", dload, dq[0].data);
          void'(dq.pop_front());
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; force_ready = 1'b0;
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  task automatic wait_done(input bit is_d, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      sample();
      if (!(is_d ? dwait : iwait)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0] grants[$];
    logic [1:0] exp_grants [6];
    bit ok;
    exp_grants = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};

    // Reset with both requests asserted.
    lat_min = 0; lat_max = 0;
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h2000; daddr = 32'h1000;
    tick();
    tick();
    sample();
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_strobes", 32'({ramREN, ramWEN}), 32'h0);
    check("rst_ramaddr", ramaddr, 32'h0);
    check("rst_ramstore", ramstore, 32'h0);
    check("rst_iwait", 32'(iwait), 32'h1);
    check("rst_dwait", 32'(dwait), 32'h1);
    tick();
    nRST = 1'b1;
    tick();
    sample();
    check("rst_release_grant", 32'(owner), 32'h2);

    // Single fetch, two-cycle RAM latency.
    lat_min = 1; lat_max = 1;
    mem[32'h40] = 32'h8C010004;
    do_reset();
    iREN = 1'b1; iaddr = 32'h40;
    for (int c = 0; c < 2; c++) begin
      tick();
      sample();
      check("fetch_ramREN", 32'(ramREN), 32'h1);
      check("fetch_ramaddr", ramaddr, 32'h40);
      check("fetch_iwait", 32'(iwait), (c == 1) ? 32'h0 : 32'h1);
    end
    check("fetch_iload", iload, 32'h8C010004);
    tick();
    iREN = 1'b0;
    sample();
    check("fetch_idle_owner", 32'(owner), 32'h0);
    check("fetch_idle_iload", iload, 32'h0);
    check("fetch_idle_ramaddr", ramaddr, 32'h0);

    // Write with address/data changed mid-access, three-cycle latency.
    lat_min = 2; lat_max = 2;
    do_reset();
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (c == 1) begin
        daddr  = 32'h200;
        dstore = 32'h12345678;
      end
      sample();
      check("wr_strobes", 32'({ramREN, ramWEN}), 32'h1);
      check("wr_ramaddr", ramaddr, 32'h100);
      check("wr_ramstore", ramstore, 32'hDEADBEEF);
      check("wr_dwait", 32'(dwait), (c == 2) ? 32'h0 : 32'h1);
    end
    tick();
    dWEN = 1'b0;
    check("wr_mem_100", mem_rd(32'h100), 32'hDEADBEEF);
    check("wr_mem_200_untouched", 32'(mem.exists(32'h200)), 32'h0);

    // Starvation bound with a zero-latency RAM.
    lat_min = 0; lat_max = 0;
    do_reset();
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h2004; daddr = 32'h1000;
    for (int c = 0; c < 14; c++) begin
      sample();
      if (owner != 2'b00) grants.push_back(owner);
      if (owner == 2'b01) check("starve_dwin_after_i", 32'(dut.dwin), 32'h0);
      tick();
    end
    iREN = 1'b0; dREN = 1'b0;
    check("starve_grant_count_ok", 32'(grants.size() >= 6), 32'h1);
    for (int g = 0; g < 6; g++)
      if (g < grants.size()) check($sformatf("starve_grant%0d", g), 32'(grants[g]), 32'(exp_grants[g]));

    // Data request dropped mid-access while a fetch waits.
    lat_min = 2; lat_max = 2;
    do_reset();
    dREN = 1'b1; daddr = 32'h1004; iREN = 1'b1; iaddr = 32'h2008;
    tick();
    sample();
    check("drop_grant", 32'(owner), 32'h2);
    tick();
    dREN = 1'b0;
    sample();
    check("drop_ramREN_held", 32'(ramREN), 32'h1);
    check("drop_dwait_low", 32'(dwait), 32'h0);
    tick();
    sample();
    check("drop_ready_cycle", 32'(ram_ready), 32'h1);
    check("drop_dload", dload, rom(32'h1004));
    check("drop_iwait", 32'(iwait), 32'h1);
    tick();
    sample();
    check("drop_gap_dload", dload, 32'h0);
    tick();
    sample();
    check("drop_next_grant_i", 32'(owner), 32'h1);
    wait_done(1'b0, ok);
    check("drop_fetch_done", 32'(ok), 32'h1);
    check("drop_fetch_iload", iload, rom(32'h2008));
    tick();
    iREN = 1'b0;

    // Reset during a data access; a late ram_ready in IDLE is ignored.
    lat_min = 5; lat_max = 5;
    do_reset();
    dREN = 1'b1; daddr = 32'h1008;
    tick();
    sample();
    check("rmid_grant", 32'(owner), 32'h2);
    tick();
    nRST = 1'b0; dREN = 1'b0;
    sample();
    check("rmid_dwait_in_reset", 32'(dwait), 32'h0);
    tick();
    nRST = 1'b1; iREN = 1'b1; iaddr = 32'h200C; force_ready = 1'b1;
    lat_min = 0; lat_max = 0;
    sample();
    check("rmid_owner_idle", 32'(owner), 32'h0);
    check("rmid_strobes", 32'({ramREN, ramWEN}), 32'h0);
    check("rmid_ready_ignored_iwait", 32'(iwait), 32'h1);
    tick();
    force_ready = 1'b0;
    sample();
    check("rmid_fetch_grant", 32'(owner), 32'h1);
    check("rmid_fetch_iwait", 32'(iwait), 32'h0);
    check("rmid_fetch_iload", iload, rom(32'h200C));
    tick();
    iREN = 1'b0;

    // Randomized two-agent traffic with random RAM latency.
    lat_min = 0; lat_max = 3;
    do_reset();
    sb_on = 1'b1;
    fork
      begin : i_agent
        for (int n = 0; n < N_TXN; n++) begin
          txn_t t;
          bit   i_ok;
          int   gap;
          t.addr  = 32'h2000 + 32'(4 * $urandom_range(0, 63));
          t.store = 32'h0;
          t.wr    = 1'b0;
          t.data  = rom(t.addr);
          iaddr = t.addr;
          iREN  = 1'b1;
          iq.push_back(t);
          wait_done(1'b0, i_ok);
          check("i_done_in_budget", 32'(i_ok), 32'h1);
          tick();
          gap = $urandom_range(0, 2);
          if (gap > 0) begin
            iREN  = 1'b0;
            iaddr = $urandom;
            repeat (gap) tick();
          end
          if (!i_ok) break;
        end
        iREN = 1'b0;
      end
      begin : d_agent
        for (int n = 0; n < N_TXN; n++) begin
          txn_t t;
          bit   d_ok;
          int   op;
          int   gap;
          op      = $urandom_range(0, 2);
          t.addr  = 32'h1000 + 32'(4 * $urandom_range(0, 7));
          t.store = $urandom;
          t.wr    = (op != 0);
          t.data  = shadow.exists(t.addr) ? shadow[t.addr] : rom(t.addr);
          if (t.wr) shadow[t.addr] = t.store;
          daddr  = t.addr;
          dstore = t.store;
          dREN   = (op != 1);
          dWEN   = t.wr;
          dq.push_back(t);
          wait_done(1'b1, d_ok);
          check("d_done_in_budget", 32'(d_ok), 32'h1);
          tick();
          gap = $urandom_range(0, 2);
          if (gap > 0) begin
            dREN   = 1'b0;
            dWEN   = 1'b0;
            daddr  = $urandom;
            dstore = $urandom;
            repeat (gap) tick();
          end
          if (!d_ok) break;
        end
        dREN = 1'b0;
        dWEN = 1'b0;
      end
    join
    tick();
    tick();
    sb_on = 1'b0;
    check("iq_drained", 32'(iq.size()), 32'h0);
    check("dq_drained", 32'(dq.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
